// File: rtl/product_accumulator.sv
// Sums COUNT unsigned products per frame and presents the frame total on a
// valid/ready output, then returns to accumulating the next frame.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int COUNT  = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_frames
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt;

  assign acc_sum   = acc + ACC_W'(in_prod);
  // Handshake flags decode straight from the state register, so they are glitch-free.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      out_sum    <= '0;
      out_frames <= '0;
    end else if (clear) begin
      // Flush wins over any beat or output handshake this cycle; out_sum keeps its value.
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              out_sum <= acc_sum;
              acc     <= '0;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              acc <= acc_sum;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_frames <= out_frames + 8'd1;
            state      <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: vector table plus hand-written
// sequences for asynchronous reset and the 256-frame wrap/throughput run.
module tb_product_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_prod;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic [7:0] out_frames;

  int total;
  int bad;

  product_accumulator #(.PROD_W(8), .COUNT(4), .ACC_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_frames (out_frames)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] prod;
    logic       ordy;
    logic       e_irdy;
    logic       e_ovld;
    int         e_sum;
    int         e_frames;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, input logic vld, input int prod, input logic ordy,
                     input logic e_irdy, input logic e_ovld, input int e_sum, input int e_frames);
    vec_t v;
    v.clr = clr; v.vld = vld; v.prod = 8'(prod); v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_sum = e_sum; v.e_frames = e_frames;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int irdy, input int ovld, input int sum, input int fr);
    chk({tag, ".in_ready"},   int'(in_ready),   irdy);
    chk({tag, ".out_valid"},  int'(out_valid),  ovld);
    chk({tag, ".out_sum"},    int'(out_sum),    sum);
    chk({tag, ".out_frames"}, int'(out_frames), fr);
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic clr, input logic vld, input int prod, input logic ordy);
    clear = clr; in_valid = vld; in_prod = 8'(prod); out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear = 0; in_valid = 0; in_prod = 0; out_ready = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int valids;
    int sum_ok;
    total = 0; bad = 0;
    rst_n = 1'b1; clear = 0; in_valid = 0; in_prod = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_all("reset", 1, 0, 0, 0);
    $display("reset: in_ready=%0d out_valid=%0d out_sum=%0d out_frames=%0d",
             in_ready, out_valid, out_sum, out_frames);

    //  clr vld prod ordy | irdy ovld sum frames
    // four back-to-back beats of 225
    add(0, 1, 225, 0,  1, 0,   0, 0);
    add(0, 1, 225, 0,  1, 0,   0, 0);
    add(0, 1, 225, 0,  1, 0,   0, 0);
    add(0, 1, 225, 0,  0, 1, 900, 0);
    add(0, 0,   0, 1,  1, 0, 900, 1);
    // beats 1..4 with idle gaps, then held off for three cycles
    add(0, 1,   1, 0,  1, 0, 900, 1);
    add(0, 0,   0, 0,  1, 0, 900, 1);
    add(0, 1,   2, 0,  1, 0, 900, 1);
    add(0, 0,  99, 0,  1, 0, 900, 1);
    add(0, 1,   3, 0,  1, 0, 900, 1);
    add(0, 1,   4, 0,  0, 1,  10, 1);
    add(0, 1,  50, 0,  0, 1,  10, 1);
    add(0, 1,  50, 0,  0, 1,  10, 1);
    add(0, 0,   0, 0,  0, 1,  10, 1);
    add(0, 0,   0, 1,  1, 0,  10, 2);
    // partial frame, clear (with a dropped beat), then 7,7,7,7; out_ready in ACCUM is inert
    add(0, 1,   5, 1,  1, 0,  10, 2);
    add(0, 1,   6, 1,  1, 0,  10, 2);
    add(1, 1,   9, 1,  1, 0,  10, 2);
    add(0, 1,   7, 0,  1, 0,  10, 2);
    add(0, 1,   7, 0,  1, 0,  10, 2);
    add(0, 1,   7, 0,  1, 0,  10, 2);
    add(0, 1,   7, 0,  0, 1,  28, 2);
    add(0, 0,   0, 1,  1, 0,  28, 3);
    // total of 40 pending, then clear (beats out_ready) discards it
    add(0, 1,  10, 0,  1, 0,  28, 3);
    add(0, 1,  10, 0,  1, 0,  28, 3);
    add(0, 1,  10, 0,  1, 0,  28, 3);
    add(0, 1,  10, 0,  0, 1,  40, 3);
    add(1, 0,   0, 1,  1, 0,  40, 3);
    add(0, 1,   1, 0,  1, 0,  40, 3);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].vld, vecs[i].prod, vecs[i].ordy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ovld, vecs[i].e_sum, vecs[i].e_frames);
      $display("vec%0d: clr=%0d vld=%0d prod=%0d ordy=%0d -> in_ready=%0d out_valid=%0d out_sum=%0d out_frames=%0d",
               i, vecs[i].clr, vecs[i].vld, vecs[i].prod, vecs[i].ordy,
               in_ready, out_valid, out_sum, out_frames);
    end

    // asynchronous reset mid-frame, asserted between clock edges
    step(0, 1, 8, 0);
    step(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1, 0, 0, 0);
    $display("async reset: in_ready=%0d out_valid=%0d out_sum=%0d out_frames=%0d",
             in_ready, out_valid, out_sum, out_frames);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk_all("post_rst", 0, 1, 4, 0);
    $display("post-reset frame: out_valid=%0d out_sum=%0d", out_valid, out_sum);

    // 256 zero frames streamed with out_ready tied high: one frame per 5 cycles
    do_reset();
    valids = 0;
    sum_ok = 1;
    for (int c = 1; c <= 1280; c++) begin
      step(0, 1, 0, 1);
      if (out_valid) begin
        valids++;
        chk($sformatf("zero_sum%0d", valids), int'(out_sum), 0);
        chk($sformatf("valid_cycle%0d", valids), c % 5, 4);
      end
      if (c == 1275) chk("frames_255", int'(out_frames), 255);
    end
    chk("zero_frames_valid", valids, 256);
    chk("frames_wrap", int'(out_frames), 0);
    chk("wrap_state_ready", int'(in_ready), 1);
    $display("zero stream: valids=%0d out_frames=%0d", valids, out_frames);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
